add_share_arb: RTL and testbench

Round-robin scheduler that shares one 16-bit carry-look-ahead adder (`cla16`) among `NREQ` requesters. Each requester presents operands with a valid/ready handshake. The block grants one requester per cycle, drives the shared adder, and registers the sum, carry, signed-overflow flag and requester ID in a one-entry output buffer with backpressure. It sits between the ALU-side clients and the single adder instance, so the team does not need one adder per client.

---
 rtl/add_share_pkg.sv | 19 +
 rtl/cla16.sv | 41 ++++
 rtl/rr_arbiter.sv | 41 ++++
 rtl/add_share_arb.sv | 82 ++++++++
 tb/tb_add_share_arb.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/add_share_pkg.sv
// Shared types and constants for the shared-adder scheduler.
package add_share_pkg;
    localparam int unsigned DATA_W   = 16;
    localparam int unsigned NREQ_DEF = 4;
    localparam int unsigned ID_MAX_W = 3;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic              cin;
    } add_req_t;

    typedef struct packed {
        logic [DATA_W-1:0]   sum;
        logic                cout;
        logic                ovf;
        logic [ID_MAX_W-1:0] id;
    } add_rsp_t;
endpackage

// File: rtl/cla16.sv
// 16-bit adder: four 4-bit groups with a look-ahead carry across groups.
module cla16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] s,
    output logic        cout
);
    logic [15:0] p, g, c;
    logic [3:0]  gp, gg;
    logic [4:0]  gc;

    assign p = a ^ b;
    assign g = a & b;

    always_comb begin
        gp = '0;
        gg = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            gp[k] = &p[4*k +: 4];
            gg[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
        end
        gc[0] = cin;
        gc[1] = gg[0] | (gp[0] & cin);
        gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
        gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0]) | (gp[2] & gp[1] & gp[0] & cin);
        gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1]) | (gp[3] & gp[2] & gp[1] & gg[0])
              | (gp[3] & gp[2] & gp[1] & gp[0] & cin);
        c = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            c[4*k] = gc[k];
            for (int unsigned j = 0; j < 3; j++) begin
                c[4*k+j+1] = g[4*k+j] | (p[4*k+j] & c[4*k+j]);
            end
        end
    end

    assign s    = p ^ c;
    assign cout = gc[4];
endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: search starts at ptr, ptr moves past the winner on a grant.
module rr_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         en,
    output logic [N-1:0] gnt
);
    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    int unsigned   idx;
    int unsigned   win;
    logic          found;

    always_comb begin
        gnt   = '0;
        idx   = 0;
        win   = 0;
        found = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = 32'(ptr) + k;
            if (idx >= N) idx = idx - N;
            if (!found && req[PW'(idx)]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        if (en && found) gnt[PW'(win)] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (en && found) begin
            ptr <= (win == N - 1) ? '0 : PW'(win + 1);
        end
    end
endmodule

// File: rtl/add_share_arb.sv
// Shares one cla16 among NREQ requesters; results land in a one-entry output buffer.
module add_share_arb
    import add_share_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEF,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*16-1:0]   req_a,
    input  logic [NREQ*16-1:0]   req_b,
    input  logic [NREQ-1:0]      req_cin,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [15:0]          rsp_sum,
    output logic                 rsp_cout,
    output logic                 rsp_ovf,
    output logic [IDW-1:0]       rsp_id
);
    logic            slot_free;
    logic            arb_en;
    logic [NREQ-1:0] gnt;
    add_req_t        op;
    logic [IDW-1:0]  gid;
    logic [15:0]     sum;
    logic            cout;

    assign slot_free = !rsp_valid | rsp_ready;
    // Gating with rst_n keeps both the grant and the pointer idle during reset.
    assign arb_en    = slot_free & rst_n;

    rr_arbiter #(.N(NREQ)) u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req_valid),
        .en    (arb_en),
        .gnt   (gnt)
    );

    assign req_ready = gnt;

    always_comb begin
        op  = '0;
        gid = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                op.a   = req_a[DATA_W*i +: DATA_W];
                op.b   = req_b[DATA_W*i +: DATA_W];
                op.cin = req_cin[i];
                gid    = IDW'(i);
            end
        end
    end

    cla16 u_add (
        .a    (op.a),
        .b    (op.b),
        .cin  (op.cin),
        .s    (sum),
        .cout (cout)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_sum   <= '0;
            rsp_cout  <= 1'b0;
            rsp_ovf   <= 1'b0;
            rsp_id    <= '0;
        end else if (|gnt) begin
            rsp_valid <= 1'b1;
            rsp_sum   <= sum;
            rsp_cout  <= cout;
            rsp_ovf   <= (op.a[15] == op.b[15]) & (sum[15] != op.a[15]);
            rsp_id    <= gid;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_add_share_arb.sv
// Bench for add_share_arb: directed scenarios plus randomized traffic against a behavioural model.
module tb_add_share_arb;
    localparam int N = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N*16-1:0] req_a = '0;
    logic [N*16-1:0] req_b = '0;
    logic [N-1:0]    req_cin = '0;
    logic            rsp_valid;
    logic            rsp_ready = 1'b1;
    logic [15:0]     rsp_sum;
    logic            rsp_cout;
    logic            rsp_ovf;
    logic [1:0]      rsp_id;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    add_share_arb #(.NREQ(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .rsp_ovf   (rsp_ovf),
        .rsp_id    (rsp_id)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: buffer contents and pointer, advanced once per cycle at the falling edge.
    bit          m_known = 0;
    bit          rst_prev = 0;
    int          m_ptr = 0;
    bit          m_valid = 0;
    logic [15:0] m_sum = '0;
    bit          m_cout = 0;
    bit          m_ovf = 0;
    int          m_id = 0;

    always @(negedge clk) begin
        int          g;
        int          j;
        logic [N-1:0] exp_rdy;
        logic [15:0] a, b;
        logic [16:0] tot;
        int          s;
        if (!rst_n) begin
            check("ready_in_reset", 32'(req_ready), 32'd0);
            if (rst_prev && m_known) begin
                check("reset_valid", 32'(rsp_valid), 32'd0);
                check("reset_sum", 32'(rsp_sum), 32'd0);
                check("reset_flags", {30'd0, rsp_cout, rsp_ovf}, 32'd0);
                check("reset_id", 32'(rsp_id), 32'd0);
            end
            m_known = 1;
            m_ptr = 0;
            m_valid = 0;
        end else if (m_known) begin
            g = -1;
            if (!m_valid || rsp_ready) begin
                for (int k = 0; k < N; k++) begin
                    j = (m_ptr + k) % N;
                    if (g < 0 && req_valid[j]) g = j;
                end
            end
            exp_rdy = '0;
            if (g >= 0) exp_rdy[g] = 1'b1;
            check("req_ready", 32'(req_ready), 32'(exp_rdy));
            check("rsp_valid", 32'(rsp_valid), 32'(m_valid));
            if (m_valid) begin
                check("rsp_sum", 32'(rsp_sum), 32'(m_sum));
                check("rsp_cout", 32'(rsp_cout), 32'(m_cout));
                check("rsp_ovf", 32'(rsp_ovf), 32'(m_ovf));
                check("rsp_id", 32'(rsp_id), 32'(m_id));
            end
            if (g >= 0) begin
                a = req_a[16*g +: 16];
                b = req_b[16*g +: 16];
                tot = {1'b0, a} + {1'b0, b} + 17'(req_cin[g]);
                s = int'($signed(a)) + int'($signed(b)) + int'(req_cin[g]);
                m_sum = tot[15:0];
                m_cout = tot[16];
                m_ovf = (s > 32767) || (s < -32768);
                m_id = g;
                m_valid = 1;
                m_ptr = (g + 1) % N;
            end else if (m_valid && rsp_ready) begin
                m_valid = 0;
            end
        end
        rst_prev = !rst_n;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input int i, input logic v, input logic [15:0] a, input logic [15:0] b, input logic c);
        req_valid[i] = v;
        req_a[16*i +: 16] = a;
        req_b[16*i +: 16] = b;
        req_cin[i] = c;
    endtask

    function automatic logic [15:0] pick();
        int r = int'($urandom_range(0, 7));
        case (r)
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h7FFF;
            3: return 16'h8000;
            default: return 16'($urandom);
        endcase
    endfunction

    logic [N-1:0] hs;

    initial begin
        // Reset with every requester asking, then round-robin fairness from ptr = 0.
        for (int i = 0; i < N; i++) put(i, 1'b1, 16'(16'h1111 * i), 16'h0001, 1'b0);
        rst_n = 1'b0;
        rsp_ready = 1'b1;
        repeat (3) tick();
        check("reset_ready_lit", 32'(req_ready), 32'd0);
        check("reset_valid_lit", 32'(rsp_valid), 32'd0);
        rst_n = 1'b1;
        #1;
        check("first_grant_lit", 32'(req_ready), 32'b0001);
        for (int k = 0; k < 6; k++) begin
            tick();
            check("rr_valid_lit", 32'(rsp_valid), 32'd1);
            check("rr_id_lit", 32'(rsp_id), 32'(k % 4));
            if (k == 0) check("rr_sum0_lit", 32'(rsp_sum), 32'h0001);
            if (k == 3) check("rr_sum3_lit", 32'(rsp_sum), 32'h3334);
        end
        req_valid = '0;
        tick();

        // Signed overflow from requester 2.
        put(2, 1'b1, 16'h7FFF, 16'h0001, 1'b0);
        tick();
        req_valid[2] = 1'b0;
        #1;
        check("add_valid_lit", 32'(rsp_valid), 32'd1);
        check("add_sum_lit", 32'(rsp_sum), 32'h8000);
        check("add_cout_lit", 32'(rsp_cout), 32'd0);
        check("add_ovf_lit", 32'(rsp_ovf), 32'd1);
        check("add_id_lit", 32'(rsp_id), 32'd2);

        // Carry-out with carry-in.
        put(1, 1'b1, 16'hFFFF, 16'h0001, 1'b1);
        tick();
        req_valid[1] = 1'b0;
        #1;
        check("cy_sum_lit", 32'(rsp_sum), 32'h0001);
        check("cy_cout_lit", 32'(rsp_cout), 32'd1);
        check("cy_ovf_lit", 32'(rsp_ovf), 32'd0);
        check("cy_id_lit", 32'(rsp_id), 32'd1);
        tick();

        // Backpressure: full buffer blocks grants, release grants on the same edge.
        rsp_ready = 1'b0;
        put(0, 1'b1, 16'h1234, 16'h1111, 1'b0);
        tick();
        req_valid[0] = 1'b0;
        put(3, 1'b1, 16'h4000, 16'h4000, 1'b0);
        #1;
        check("bp_sum_lit", 32'(rsp_sum), 32'h2345);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("bp_ready_lit", 32'(req_ready), 32'd0);
            check("bp_hold_lit", {15'd0, rsp_valid, rsp_sum}, {15'd0, 1'b1, 16'h2345});
        end
        rsp_ready = 1'b1;
        #1;
        check("bp_resume_lit", 32'(req_ready), 32'b1000);
        tick();
        req_valid[3] = 1'b0;
        #1;
        check("bp_new_id_lit", 32'(rsp_id), 32'd3);
        check("bp_new_res_lit", {14'd0, rsp_cout, rsp_ovf, rsp_sum}, {14'd0, 1'b0, 1'b1, 16'h8000});

        // Reset while the buffer is full and requester 1 waits.
        rsp_ready = 1'b0;
        put(1, 1'b1, 16'h0005, 16'h0006, 1'b0);
        #1;
        check("mid_full_lit", 32'(req_ready), 32'd0);
        rst_n = 1'b0;
        tick();
        check("mid_valid_lit", 32'(rsp_valid), 32'd0);
        check("mid_ready_lit", 32'(req_ready), 32'd0);
        put(0, 1'b1, 16'h0002, 16'h0003, 1'b0);
        rst_n = 1'b1;
        #1;
        check("mid_ptr_lit", 32'(req_ready), 32'b0001);
        tick();
        check("mid_id_lit", 32'(rsp_id), 32'd0);
        req_valid = '0;
        rsp_ready = 1'b1;
        tick();

        // Randomized traffic; requesters hold operands until their handshake completes.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            hs = req_valid & req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (hs[i]) req_valid[i] = 1'b0;
                if (!req_valid[i] && $urandom_range(0, 99) < 50)
                    put(i, 1'b1, pick(), pick(), 1'($urandom_range(0, 1)));
            end
            rsp_ready = ($urandom_range(0, 99) < 70);
            rst_n = ($urandom_range(0, 399) != 0);
        end
        rst_n = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
